// File: rtl/rename_pkg.sv
// Shared sizing and types for the rename-stage physical register allocator.
package rename_pkg;

  localparam int NUM_PHYS      = 64;
  localparam int NUM_ARCH      = 32;
  localparam int FL_DEPTH      = NUM_PHYS - NUM_ARCH;
  localparam int CKPT_DEPTH    = 4;
  localparam int PREG_BITS     = $clog2(NUM_PHYS);
  localparam int FL_IDX_BITS   = $clog2(FL_DEPTH);
  localparam int FL_PTR_BITS   = FL_IDX_BITS + 1;
  localparam int CKPT_IDX_BITS = $clog2(CKPT_DEPTH);
  localparam int CKPT_PTR_BITS = CKPT_IDX_BITS + 1;

  typedef logic [PREG_BITS-1:0]     preg_t;
  typedef logic [FL_PTR_BITS-1:0]   fl_ptr_t;
  typedef logic [CKPT_IDX_BITS-1:0] ckpt_idx_t;
  typedef logic [CKPT_PTR_BITS-1:0] ckpt_ptr_t;

endpackage

// File: rtl/free_list_ctrl_if.sv
// Rename-side handshake bundle for the free-list controller.
interface free_list_ctrl_if;
  import rename_pkg::*;

  logic      alloc_req;
  logic      alloc_gnt;
  preg_t     alloc_preg;
  logic      rel_valid;
  preg_t     rel_preg;
  logic      ckpt_save;
  logic      ckpt_ack;
  ckpt_idx_t ckpt_id;
  logic      br_correct;
  logic      br_flush;
  logic      rename_stall;
  fl_ptr_t   free_count;
  ckpt_ptr_t ckpt_count;

  modport slave (
    input  alloc_req, rel_valid, rel_preg,
    input  ckpt_save, br_correct, br_flush,
    output alloc_gnt, alloc_preg, ckpt_ack,
    output ckpt_id, rename_stall,
    output free_count, ckpt_count
  );

  modport master (
    output alloc_req, rel_valid, rel_preg,
    output ckpt_save, br_correct, br_flush,
    input  alloc_gnt, alloc_preg, ckpt_ack,
    input  ckpt_id, rename_stall,
    input  free_count, ckpt_count
  );

endinterface

// File: rtl/ckpt_fifo.sv
// FIFO of saved free-list head pointers, one per unresolved branch.
module ckpt_fifo
  import rename_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  fl_ptr_t   push_data,
  input  logic      pop,
  input  logic      clear,
  output fl_ptr_t   head_data,
  output ckpt_idx_t wr_idx,
  output ckpt_ptr_t count,
  output logic      full
);

  fl_ptr_t   mem_q [CKPT_DEPTH];
  fl_ptr_t   mem_d [CKPT_DEPTH];
  ckpt_ptr_t wr_ptr_q, wr_ptr_d;
  ckpt_ptr_t rd_ptr_q, rd_ptr_d;

  assign wr_idx    = wr_ptr_q[CKPT_IDX_BITS-1:0];
  assign head_data = mem_q[rd_ptr_q[CKPT_IDX_BITS-1:0]];
  assign count     = wr_ptr_q - rd_ptr_q;
  assign full      = (count == ckpt_ptr_t'(CKPT_DEPTH));

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) begin
        mem_d[wr_idx] = push_data;
        wr_ptr_d      = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CKPT_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/free_list_ctrl.sv
// Physical register free list with branch checkpoint/rewind of the head.
module free_list_ctrl
  import rename_pkg::*;
(
  input logic              clk,
  input logic              rst,
  free_list_ctrl_if.slave  bus
);

  if ((FL_DEPTH & (FL_DEPTH - 1)) != 0 ||
      (CKPT_DEPTH & (CKPT_DEPTH - 1)) != 0) begin : g_pow2
    $error("free_list_ctrl: depths must be powers of two");
  end

  preg_t   fl_q [FL_DEPTH];
  preg_t   fl_d [FL_DEPTH];
  fl_ptr_t head_q, head_d;
  fl_ptr_t tail_q, tail_d;

  fl_ptr_t free_count;
  logic    fl_empty;
  logic    ckpt_full;
  fl_ptr_t ckpt_head;
  fl_ptr_t head_post_alloc;

  assign free_count = tail_q - head_q;
  assign fl_empty   = (free_count == '0);

  assign bus.alloc_gnt = bus.alloc_req & ~fl_empty &
                         ~bus.br_flush &
                         ~(bus.ckpt_save & ckpt_full);
  assign bus.ckpt_ack  = bus.ckpt_save & ~ckpt_full &
                         ~bus.br_flush &
                         (~fl_empty | ~bus.alloc_req);
  assign bus.alloc_preg   = fl_q[head_q[FL_IDX_BITS-1:0]];
  assign bus.rename_stall = (bus.alloc_req & fl_empty) |
                            (bus.ckpt_save & ckpt_full);
  assign bus.free_count   = free_count;

  // Snapshot includes the branch's own destination so it survives rewind.
  assign head_post_alloc = head_q + fl_ptr_t'(bus.alloc_gnt);

  always_comb begin
    fl_d   = fl_q;
    tail_d = tail_q;
    head_d = bus.br_flush ? ckpt_head : head_post_alloc;
    if (bus.rel_valid) begin
      fl_d[tail_q[FL_IDX_BITS-1:0]] = bus.rel_preg;
      tail_d = tail_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FL_DEPTH; i++)
        fl_q[i] <= preg_t'(NUM_ARCH + i);
      head_q <= '0;
      tail_q <= fl_ptr_t'(FL_DEPTH);
    end else begin
      fl_q   <= fl_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  ckpt_fifo u_ckpt (
    .clk       (clk),
    .rst       (rst),
    .push      (bus.ckpt_ack),
    .push_data (head_post_alloc),
    .pop       (bus.br_correct & ~bus.br_flush),
    .clear     (bus.br_flush),
    .head_data (ckpt_head),
    .wr_idx    (bus.ckpt_id),
    .count     (bus.ckpt_count),
    .full      (ckpt_full)
  );

endmodule

// File: tb/tb_free_list_ctrl.sv
// Directed bench for free_list_ctrl: allocation, release, checkpoints, flush, reset.
module tb_free_list_ctrl;
  import rename_pkg::*;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  free_list_ctrl_if bus ();

  free_list_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.alloc_req  = 1'b0;
    bus.rel_valid  = 1'b0;
    bus.rel_preg   = '0;
    bus.ckpt_save  = 1'b0;
    bus.br_correct = 1'b0;
    bus.br_flush   = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle();
    @(negedge clk);
    rst = 1'b0;
  endtask

  always @(posedge clk) begin
    if (!rst) begin
      assert (!(bus.rel_valid && bus.free_count == fl_ptr_t'(FL_DEPTH)))
      else begin
        bad++;
        $error("FAIL illegal_release observed=1 expected=0");
      end
      assert (!((bus.br_flush || bus.br_correct) && bus.ckpt_count == 0))
      else begin
        bad++;
        $error("FAIL illegal_resolve observed=1 expected=0");
      end
    end
  end

  initial begin
    rst = 1'b1;
    idle();
    #1;
    chk("rst_gnt", bus.alloc_gnt, 0);
    chk("rst_ack", bus.ckpt_ack, 0);
    chk("rst_stall", bus.rename_stall, 0);
    chk("rst_free", bus.free_count, 32);
    chk("rst_ckcnt", bus.ckpt_count, 0);
    @(negedge clk);
    rst = 1'b0;

    // drain the whole list
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      bus.alloc_req = 1'b1;
      #1;
      chk("drain_gnt", bus.alloc_gnt, 1);
      chk("drain_preg", bus.alloc_preg, 32 + i);
      chk("drain_free", bus.free_count, 32 - i);
    end
    @(negedge clk);
    #1;
    chk("empty_gnt", bus.alloc_gnt, 0);
    chk("empty_stall", bus.rename_stall, 1);
    chk("empty_free", bus.free_count, 0);

    // release does not bypass into same-cycle alloc
    @(negedge clk);
    bus.rel_valid = 1'b1;
    bus.rel_preg  = 6'd5;
    #1;
    chk("nobypass_gnt", bus.alloc_gnt, 0);
    @(negedge clk);
    bus.rel_valid = 1'b0;
    #1;
    chk("rel_free", bus.free_count, 1);
    chk("rel_gnt", bus.alloc_gnt, 1);
    chk("rel_preg", bus.alloc_preg, 5);
    @(negedge clk);
    bus.alloc_req = 1'b0;
    #1;
    chk("rel_free0", bus.free_count, 0);

    // checkpoint with alloc, then flush
    do_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus.alloc_req = 1'b1;
      #1;
      chk("pre_preg", bus.alloc_preg, 32 + i);
    end
    @(negedge clk);
    bus.ckpt_save = 1'b1;
    #1;
    chk("save_gnt", bus.alloc_gnt, 1);
    chk("save_preg", bus.alloc_preg, 34);
    chk("save_ack", bus.ckpt_ack, 1);
    chk("save_id", bus.ckpt_id, 0);
    @(negedge clk);
    bus.ckpt_save = 1'b0;
    #1;
    chk("post_preg35", bus.alloc_preg, 35);
    @(negedge clk);
    #1;
    chk("post_preg36", bus.alloc_preg, 36);
    @(negedge clk);
    bus.alloc_req = 1'b0;
    bus.br_flush  = 1'b1;
    #1;
    chk("flush_ckcnt_pre", bus.ckpt_count, 1);
    @(negedge clk);
    bus.br_flush  = 1'b0;
    bus.alloc_req = 1'b1;
    #1;
    chk("flush_free", bus.free_count, 29);
    chk("flush_ckcnt", bus.ckpt_count, 0);
    chk("flush_gnt", bus.alloc_gnt, 1);
    chk("flush_preg", bus.alloc_preg, 35);

    // fill the checkpoint FIFO
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.alloc_req = 1'b0;
      bus.ckpt_save = 1'b1;
      #1;
      chk("fill_ack", bus.ckpt_ack, 1);
      chk("fill_id", bus.ckpt_id, i);
    end
    @(negedge clk);
    bus.br_correct = 1'b1;
    #1;
    chk("full_cnt", bus.ckpt_count, 4);
    chk("full_ack", bus.ckpt_ack, 0);
    chk("full_stall", bus.rename_stall, 1);
    @(negedge clk);
    bus.br_correct = 1'b0;
    #1;
    chk("retry_cnt", bus.ckpt_count, 3);
    chk("retry_ack", bus.ckpt_ack, 1);
    chk("retry_id", bus.ckpt_id, 0);
    chk("retry_stall", bus.rename_stall, 0);

    // flush overrides alloc/save, release still lands
    @(negedge clk);
    bus.br_flush  = 1'b1;
    bus.alloc_req = 1'b1;
    bus.rel_valid = 1'b1;
    bus.rel_preg  = 6'd7;
    #1;
    chk("ovr_cnt", bus.ckpt_count, 4);
    chk("ovr_gnt", bus.alloc_gnt, 0);
    chk("ovr_ack", bus.ckpt_ack, 0);
    chk("ovr_free", bus.free_count, 28);
    @(negedge clk);
    idle();
    #1;
    chk("ovr_cnt0", bus.ckpt_count, 0);
    chk("ovr_free1", bus.free_count, 29);
    chk("ovr_head", bus.alloc_preg, 36);
    for (int i = 0; i < 28; i++) begin
      @(negedge clk);
      bus.alloc_req = 1'b1;
      #1;
      chk("walk_preg", bus.alloc_preg, 36 + i);
    end
    @(negedge clk);
    #1;
    chk("walk_rel7_gnt", bus.alloc_gnt, 1);
    chk("walk_rel7", bus.alloc_preg, 7);
    @(negedge clk);
    bus.alloc_req = 1'b0;
    #1;
    chk("walk_free0", bus.free_count, 0);

    // asynchronous reset mid-burst
    do_reset();
    @(negedge clk);
    bus.alloc_req = 1'b1;
    bus.ckpt_save = 1'b1;
    @(negedge clk);
    bus.ckpt_save = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    idle();
    #1;
    chk("arst_free", bus.free_count, 32);
    chk("arst_ckcnt", bus.ckpt_count, 0);
    chk("arst_gnt", bus.alloc_gnt, 0);
    chk("arst_head", bus.alloc_preg, 32);
    @(negedge clk);
    rst = 1'b0;
    bus.alloc_req = 1'b1;
    #1;
    chk("arst_post_gnt", bus.alloc_gnt, 1);
    chk("arst_post_preg", bus.alloc_preg, 32);
    @(negedge clk);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
